systolic_array_is_engine: RTL and testbench

Self-contained, parametrised input-stationary systolic engine: a rectangular MAC array with an integrated sequencer. It loads a stationary input tile over a valid/ready port, streams any number of weight vectors through skewed weight entry, and emits de-skewed partial-sum vectors with a fixed latency and a valid flag. It replaces bare array instances driven by an external controller. It sits between the input/weight buffers and the output accumulator of the accelerator datapath.

---
 rtl/systolic_array_is_engine_if.sv | 34 +++
 rtl/systolic_array_is_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_systolic_array_is_engine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_is_engine_if.sv
// Signal bundle for systolic_array_is_engine: job control, tile-load beats,
// weight-vector stream and de-skewed result vectors.
interface systolic_array_is_engine_if #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int CNT_WIDTH    = 16
);
    logic                                 start;
    logic                                 reuse;
    logic [CNT_WIDTH-1:0]                 num_vectors;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [INPUT_WIDTH*ARRAY_HEIGHT-1:0]  packed_input_in;
    logic                                 w_valid;
    logic                                 w_ready;
    logic [WEIGHT_WIDTH*ARRAY_WIDTH-1:0]  packed_weight_in;
    logic                                 out_valid;
    logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]   packed_psum_out;
    logic                                 busy;
    logic                                 done;

    modport master (
        output start, reuse, num_vectors, in_valid, packed_input_in, w_valid, packed_weight_in,
        input  in_ready, w_ready, out_valid, packed_psum_out, busy, done
    );

    modport slave (
        input  start, reuse, num_vectors, in_valid, packed_input_in, w_valid, packed_weight_in,
        output in_ready, w_ready, out_valid, packed_psum_out, busy, done
    );
endinterface

// File: rtl/systolic_array_is_engine.sv
// Input-stationary systolic MAC array with built-in job sequencer.
// Define SA_IS_SATURATE_EN to clamp products and accumulations instead of wrapping.
module systolic_array_is_engine #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int CNT_WIDTH    = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    systolic_array_is_engine_if.slave io
);
    localparam int H      = ARRAY_HEIGHT;
    localparam int W      = ARRAY_WIDTH;
    localparam int L      = ARRAY_WIDTH + ARRAY_HEIGHT;
    localparam int PROD_W = INPUT_WIDTH + WEIGHT_WIDTH;
`ifdef SA_IS_SATURATE_EN
    localparam int EXT_W  = ((PROD_W > PSUM_WIDTH) ? PROD_W : PSUM_WIDTH) + 1;
    localparam logic signed [EXT_W-1:0] PMAX =
        {{(EXT_W-PSUM_WIDTH+1){1'b0}}, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] PMIN =
        {{(EXT_W-PSUM_WIDTH+1){1'b1}}, {(PSUM_WIDTH-1){1'b0}}};
`endif

    function automatic logic signed [PSUM_WIDTH-1:0] to_psum(input logic signed [PROD_W-1:0] p);
`ifdef SA_IS_SATURATE_EN
        logic signed [EXT_W-1:0] x;
        x = EXT_W'(p);
        if (x > PMAX) return PMAX[PSUM_WIDTH-1:0];
        if (x < PMIN) return PMIN[PSUM_WIDTH-1:0];
        return x[PSUM_WIDTH-1:0];
`else
        return PSUM_WIDTH'(p);
`endif
    endfunction

    function automatic logic signed [PSUM_WIDTH-1:0] add_psum(input logic signed [PSUM_WIDTH-1:0] a,
                                                              input logic signed [PSUM_WIDTH-1:0] b);
`ifdef SA_IS_SATURATE_EN
        logic signed [PSUM_WIDTH:0] s;
        s = (PSUM_WIDTH+1)'(a) + (PSUM_WIDTH+1)'(b);
        if (s[PSUM_WIDTH] != s[PSUM_WIDTH-1])
            return s[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        return s[PSUM_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic signed [PSUM_WIDTH-1:0] mac(input logic signed [PSUM_WIDTH-1:0]   acc,
                                                         input logic signed [INPUT_WIDTH-1:0]  a,
                                                         input logic signed [WEIGHT_WIDTH-1:0] b);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(a) * PROD_W'(b);
        return add_psum(acc, to_psum(prod));
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx, n_reg, n_nx;
    logic                 in_ready, w_ready, in_acc, w_acc;
    logic [L-1:0]         vld_p;
    logic                 out_vld_p;
    logic [PSUM_WIDTH*H-1:0] psum_out_p;

    logic signed [INPUT_WIDTH-1:0]  tile_p [H][W];
    logic signed [WEIGHT_WIDTH-1:0] w_top  [W];
    logic signed [WEIGHT_WIDTH-1:0] w_in   [H][W];
    logic signed [WEIGHT_WIDTH-1:0] w_p    [H][W];
    logic signed [PSUM_WIDTH-1:0]   ps_in  [H][W];
    logic signed [PSUM_WIDTH-1:0]   psum_p [H][W];
    logic signed [PSUM_WIDTH-1:0]   row_res[H];

    assign in_acc       = in_ready & io.in_valid;
    assign w_acc        = w_ready & io.w_valid;
    assign io.in_ready  = in_ready;
    assign io.w_ready   = w_ready;
    assign io.busy      = (state != S_IDLE);
    assign io.done      = (state == S_DONE);
    assign io.out_valid = out_vld_p;
    assign io.packed_psum_out = psum_out_p;

    // cnt is reused: tile beat index in LOAD, accepts in STREAM, elapsed cycles in DRAIN
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        n_nx     = n_reg;
        in_ready = 1'b0;
        w_ready  = 1'b0;
        unique case (state)
            S_IDLE: if (io.start) begin
                n_nx     = io.num_vectors;
                cnt_nx   = '0;
                state_nx = io.reuse ? S_STREAM : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (io.in_valid) begin
                    if (cnt == CNT_WIDTH'(W - 1)) begin
                        cnt_nx   = '0;
                        state_nx = (n_reg == '0) ? S_DRAIN : S_STREAM;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (cnt < n_reg) begin
                    w_ready = 1'b1;
                    if (io.w_valid) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt_nx == n_reg) begin
                            cnt_nx   = '0;
                            state_nx = S_DRAIN;
                        end
                    end
                end else begin
                    cnt_nx   = '0;
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_WIDTH'(L)) begin
                    cnt_nx   = '0;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            n_reg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            n_reg <= n_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    tile_p[r][c] <= '0;
        end else if (in_acc) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    if (cnt == CNT_WIDTH'(c))
                        tile_p[r][c] <= io.packed_input_in[r*INPUT_WIDTH +: INPUT_WIDTH];
        end
    end

    // weight skew: column c sees the accepted vector c cycles later; bubbles enter as zero
    for (genvar c = 0; c < W; c++) begin : g_skew
        logic signed [WEIGHT_WIDTH-1:0] dly_p [c+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= c; j++) dly_p[j] <= '0;
            end else begin
                dly_p[0] <= w_acc ? io.packed_weight_in[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
                for (int j = 1; j <= c; j++) dly_p[j] <= dly_p[j-1];
            end
        end
        assign w_top[c] = dly_p[c];
    end

    for (genvar r = 0; r < H; r++) begin : g_row
        for (genvar c = 0; c < W; c++) begin : g_col
            if (r == 0) begin : g_wtop
                assign w_in[r][c] = w_top[c];
            end else begin : g_wdown
                assign w_in[r][c] = w_p[r-1][c];
            end
            if (c == 0) begin : g_pzero
                assign ps_in[r][c] = '0;
            end else begin : g_pleft
                assign ps_in[r][c] = psum_p[r][c-1];
            end
        end
    end

    // PE grid: weights move down, psums move right, one step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    w_p[r][c]    <= '0;
                    psum_p[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    w_p[r][c]    <= w_in[r][c];
                    psum_p[r][c] <= mac(ps_in[r][c], tile_p[r][c], w_in[r][c]);
                end
        end
    end

    // de-skew: row r finishes r cycles after row 0, so it waits H-1-r extra cycles
    for (genvar r = 0; r < H; r++) begin : g_dsk
        if (r == H - 1) begin : g_none
            assign row_res[r] = psum_p[r][W-1];
        end else begin : g_dly
            logic signed [PSUM_WIDTH-1:0] dsk_p [H-1-r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < H-1-r; j++) dsk_p[j] <= '0;
                end else begin
                    dsk_p[0] <= psum_p[r][W-1];
                    for (int j = 1; j < H-1-r; j++) dsk_p[j] <= dsk_p[j-1];
                end
            end
            assign row_res[r] = dsk_p[H-2-r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p      <= '0;
            out_vld_p  <= 1'b0;
            psum_out_p <= '0;
        end else begin
            vld_p     <= {vld_p[L-2:0], w_acc};
            out_vld_p <= vld_p[L-1];
            if (vld_p[L-1])
                for (int r = 0; r < H; r++)
                    psum_out_p[r*PSUM_WIDTH +: PSUM_WIDTH] <= row_res[r];
        end
    end
endmodule

// File: tb/tb_systolic_array_is_engine.sv
// Scoreboard bench for systolic_array_is_engine: expected vectors queued at accept,
// compared with data and exact cycle when out_valid appears.
module tb_systolic_array_is_engine;
    localparam int IW = 16, WW = 16, PW = 32, H = 4, W = 4, CW = 16;
    localparam int L  = W + H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_array_is_engine_if #(.INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
        .ARRAY_HEIGHT(H), .ARRAY_WIDTH(W), .CNT_WIDTH(CW)) bus ();

    systolic_array_is_engine #(.INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .PSUM_WIDTH(PW),
        .ARRAY_HEIGHT(H), .ARRAY_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .io(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int tile_m [H][W];
    logic [W*WW-1:0] wq[$];
    logic [H*PW-1:0] exp_q[$];
    int              exp_cyc_q[$];

`ifdef SA_IS_SATURATE_EN
    function automatic longint clamp(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (PW-1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction
`endif

    function automatic logic [H*PW-1:0] model(input logic [W*WW-1:0] wv);
        logic [H*PW-1:0] res;
        longint acc, p;
        logic [63:0] bits;
        res = '0;
        for (int r = 0; r < H; r++) begin
            acc = 0;
            for (int c = 0; c < W; c++) begin
                p = longint'(tile_m[r][c]) * longint'($signed(wv[c*WW +: WW]));
`ifdef SA_IS_SATURATE_EN
                acc = clamp(acc + clamp(p));
`else
                acc = acc + p;
`endif
            end
            bits = acc;
            res[r*PW +: PW] = bits[PW-1:0];
        end
        return res;
    endfunction

    function automatic logic [W*WW-1:0] wvec4(input int a, input int b, input int c, input int d);
        logic [W*WW-1:0] v;
        v = {WW'(d), WW'(c), WW'(b), WW'(a)};
        return v;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drive_idle();
        bus.start = 1'b0; bus.reuse = 1'b0; bus.num_vectors = '0;
        bus.in_valid = 1'b0; bus.packed_input_in = '0;
        bus.w_valid = 1'b0; bus.packed_weight_in = '0;
    endtask

    task automatic run_job(input bit reuse_i, input int n, input bit gaps);
        int start_edge, drain_edge, sent, budget, last_out, wc, want_done;
        bit fin, phase;
        logic [H*PW-1:0] want;
        sent = 0; fin = 1'b0; phase = 1'b0; drain_edge = -1; last_out = -1;
        bus.start = 1'b1; bus.reuse = reuse_i; bus.num_vectors = CW'(n);
        start_edge = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
        n_cmp++;
        if (bus.in_ready !== ~reuse_i) begin
            n_bad++; $display("FAIL in_ready_after_start: got %b want %b", bus.in_ready, ~reuse_i);
        end
        if (!reuse_i) begin
            for (int k = 0; k < W; k++) begin
                bus.in_valid = 1'b1;
                for (int r = 0; r < H; r++) bus.packed_input_in[r*IW +: IW] = IW'(tile_m[r][k]);
                if (k == W - 1) drain_edge = cyc + 1;
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
        end else begin
            drain_edge = start_edge + 1;
        end
        budget = 4 * (n + L) + 40;
        while (!fin) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out_valid: cycle %0d got %h want no output", cyc, bus.packed_psum_out);
                end else begin
                    want = exp_q.pop_front();
                    wc   = exp_cyc_q.pop_front();
                    n_cmp++;
                    if (bus.packed_psum_out !== want) begin
                        n_bad++; $display("FAIL result_data: got %h want %h", bus.packed_psum_out, want);
                    end
                    n_cmp++;
                    if (cyc !== wc) begin
                        n_bad++; $display("FAIL result_latency: got cycle %0d want cycle %0d", cyc, wc);
                    end
                    last_out = cyc;
                end
            end
            if (bus.done === 1'b1) begin
                fin = 1'b1;
                n_cmp++;
                if (sent !== n || exp_q.size() != 0) begin
                    n_bad++; $display("FAIL done_early: sent %0d of %0d, %0d results pending", sent, n, exp_q.size());
                end
                want_done = (n > 0) ? last_out + 1 : drain_edge + L + 1;
                n_cmp++;
                if (cyc !== want_done) begin
                    n_bad++; $display("FAIL done_timing: got cycle %0d want cycle %0d", cyc, want_done);
                end
            end else begin
                bus.w_valid = 1'b0;
                if (sent < n && (!gaps || !phase)) begin
                    bus.w_valid = 1'b1;
                    bus.packed_weight_in = wq[sent];
                    if (bus.w_ready === 1'b1) begin
                        exp_q.push_back(model(wq[sent]));
                        exp_cyc_q.push_back(cyc + 1 + L);
                        sent++;
                        if (sent == n) drain_edge = cyc + 1;
                    end
                end
                phase = ~phase;
                @(negedge clk);
                budget--;
                if (budget == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL job_timeout: no done, sent %0d of %0d", sent, n);
                    fin = 1'b1;
                end
            end
        end
        bus.w_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_after_done: got %b want 0", bus.busy);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse_width: got %b want 0", bus.done);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.w_ready !== 1'b0) begin n_bad++; $display("FAIL reset_w_ready: got %b want 0", bus.w_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.packed_psum_out !== '0) begin n_bad++; $display("FAIL reset_psum: got %h want 0", bus.packed_psum_out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tile_m[r][c] = (r == c) ? 1 : 0;
        wq.delete();
        wq.push_back(wvec4(1, 2, 3, 4));
        run_job(1'b0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tile_m[r][c] = 2;
        wq.delete();
        for (int n = 1; n <= 5; n++) wq.push_back(wvec4(n, n, n, n));
        run_job(1'b0, 5, 1'b0);
    endtask

    task automatic test_gaps();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tile_m[r][c] = rnd16();
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(wvec4(rnd16(), rnd16(), rnd16(), rnd16()));
        run_job(1'b0, 3, 1'b1);
    endtask

    task automatic test_reuse_and_empty();
        wq.delete();
        wq.push_back(wvec4(-7, 100, 3, -32768));
        wq.push_back(wvec4(32767, -1, 0, 9));
        run_job(1'b1, 2, 1'b0);
        wq.delete();
        run_job(1'b1, 0, 1'b0);
        run_job(1'b0, 0, 1'b0);
    endtask

    task automatic test_wrap_extremes();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tile_m[r][c] = 32767;
        wq.delete();
        wq.push_back(wvec4(32767, 32767, 32767, 32767));
        wq.push_back(wvec4(-32768, -32768, -32768, -32768));
        wq.push_back(wvec4(-32768, 32767, -32768, 32767));
        run_job(1'b0, 3, 1'b0);
    endtask

    task automatic test_mid_reset();
        int seen;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tile_m[r][c] = rnd16();
        bus.start = 1'b1; bus.reuse = 1'b0; bus.num_vectors = CW'(12);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < W; k++) begin
            bus.in_valid = 1'b1;
            for (int r = 0; r < H; r++) bus.packed_input_in[r*IW +: IW] = IW'(tile_m[r][k]);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.w_valid = 1'b1;
            bus.packed_weight_in = wvec4(i + 1, -i, 3, 5);
            @(negedge clk);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_out_valid: got %b want 1", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.packed_psum_out !== '0) begin n_bad++; $display("FAIL midreset_psum: got %h want 0", bus.packed_psum_out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.w_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_w_ready: got %b want 0", bus.w_ready); end
        bus.w_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * L; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen);
        end
        exp_q.delete();
        exp_cyc_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) tile_m[r][c] = 0;
        wq.delete();
        wq.push_back(wvec4(5, 6, 7, 8));
        run_job(1'b1, 1, 1'b0);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_identity();
        test_back_to_back();
        test_gaps();
        test_reuse_and_empty();
        test_wrap_extremes();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
